// File: rtl/mano_ctrl_seq_if.sv
// Mano control sequencer bus: SC value, IR, flags
// and the decoded timing/strobe outputs.
interface mano_ctrl_seq_if #(
  parameter int SEQW = 4,
  parameter int NT   = 16
);
  logic [SEQW-1:0] t;
  logic [15:0]     ir;
  logic            fgi;
  logic            fgo;
  logic            start;
  logic            sc_clr;
  logic            sc_inc;
  logic [NT-1:0]   tsig;
  logic [7:0]      d;
  logic            i_ff;
  logic            r_ff;
  logic            ien;
  logic            s_run;
  logic [2:0]      phase;
  logic            ld_ar_pc;
  logic            ld_ir;
  logic            ld_ar_ir;
  logic            ld_ar_mem;
  logic [2:0]      intr_step;
  logic            err;

  modport master (
    output t, ir, fgi, fgo, start,
    input  sc_clr, sc_inc, tsig, d, i_ff,
    input  r_ff, ien, s_run, phase,
    input  ld_ar_pc, ld_ir, ld_ar_ir,
    input  ld_ar_mem, intr_step, err
  );

  modport slave (
    input  t, ir, fgi, fgo, start,
    output sc_clr, sc_inc, tsig, d, i_ff,
    output r_ff, ien, s_run, phase,
    output ld_ar_pc, ld_ir, ld_ar_ir,
    output ld_ar_mem, intr_step, err
  );
endinterface

// File: rtl/mano_ctrl_seq.sv
// Mano control sequencer: timing decode, instruction
// cycle phase, R/IEN/S/I flops and fetch/intr strobes.
module mano_ctrl_seq #(
  parameter int SEQW = 4,
  parameter int NT   = 16
) (
  input logic              clk,
  input logic              rst,
  mano_ctrl_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_HALT,
    ST_RUN,
    ST_INTR
  } state_e;

  localparam logic [2:0] PH_HALT = 3'd0;
  localparam logic [2:0] PH_FETCH = 3'd1;
  localparam logic [2:0] PH_DEC = 3'd2;
  localparam logic [2:0] PH_IND = 3'd3;
  localparam logic [2:0] PH_EXEC = 3'd4;
  localparam logic [2:0] PH_INTR = 3'd5;

  state_e        state_q;
  state_e        state_d;
  logic [7:0]    d_q;
  logic          i_q;
  logic          ien_q;
  logic          err_q;

  logic [NT-1:0] tr;
  logic          run;
  logic          rmode;
  logic          fault;
  logic          term;
  logic          intr_end;
  logic          halt;
  logic          io;
  logic          rset;
  logic          fetch;
  logic          unused;

  assign unused = ^{bus.ir[11:8], bus.ir[5:1]};

  assign tr = {{(NT-1){1'b0}}, 1'b1} << bus.t;
  assign run = (state_q != ST_HALT) & ~rst;
  assign rmode = (state_q == ST_INTR);
  assign fault = run & (bus.t >= SEQW'(7));

  // the executing instruction ends when its last timing step is reached
  assign term = (d_q[7] & tr[3])
              | ((d_q[3] | d_q[4]) & tr[4])
              | ((d_q[0] | d_q[1] | d_q[2] | d_q[5]) & tr[5])
              | (d_q[6] & tr[6]);

  assign intr_end = rmode & tr[2];
  assign halt = ~rmode & d_q[7] & ~i_q & tr[3] & bus.ir[0];
  assign io = ~rmode & d_q[7] & i_q & tr[3];
  assign rset = ~rmode & ien_q & (bus.fgi | bus.fgo)
              & ~(tr[0] | tr[1] | tr[2]);
  assign fetch = run & ~rmode;

  assign bus.sc_clr = ~run | fault | term | intr_end;
  assign bus.sc_inc = run & ~bus.sc_clr;
  assign bus.tsig = run ? tr : '0;
  assign bus.ld_ar_pc = fetch & tr[0];
  assign bus.ld_ir = fetch & tr[1];
  assign bus.ld_ar_ir = fetch & tr[2];
  assign bus.ld_ar_mem = fetch & ~d_q[7] & i_q & tr[3];
  assign bus.intr_step = (run & rmode) ? tr[2:0] : 3'b000;
  assign bus.d = d_q;
  assign bus.i_ff = i_q;
  assign bus.r_ff = rmode;
  assign bus.ien = ien_q;
  assign bus.s_run = (state_q != ST_HALT);
  assign bus.err = err_q;

  // phase reported for the current cycle, highest priority first
  always_comb begin
    bus.phase = PH_EXEC;
    if (!run) bus.phase = PH_HALT;
    else if (rmode) bus.phase = PH_INTR;
    else if (tr[0] | tr[1]) bus.phase = PH_FETCH;
    else if (tr[2]) bus.phase = PH_DEC;
    else if (tr[3] & ~d_q[7] & i_q) bus.phase = PH_IND;
  end

  // S/R state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_HALT;
    else state_q <= state_d;
  end

  // run/halt/interrupt transitions; halt beats a pending interrupt
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_HALT: if (bus.start) state_d = ST_RUN;
      ST_RUN: begin
        if (halt) state_d = ST_HALT;
        else if (rset) state_d = ST_INTR;
      end
      ST_INTR: if (tr[2]) state_d = ST_RUN;
      default: state_d = ST_HALT;
    endcase
  end

  // opcode decode, IEN control and sticky fault flag
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= 8'h00;
      i_q <= 1'b0;
      ien_q <= 1'b0;
      err_q <= 1'b0;
    end else if (state_q != ST_HALT) begin
      if (fault) err_q <= 1'b1;
      if (intr_end) begin
        ien_q <= 1'b0;
      end else if (io) begin
        if (bus.ir[6]) ien_q <= 1'b0;
        else if (bus.ir[7]) ien_q <= 1'b1;
      end
      if (~rmode & tr[2]) begin
        d_q <= 8'h01 << bus.ir[14:12];
        i_q <= bus.ir[15];
      end
    end
  end

endmodule
